// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute-facing bundle of the branch resolve queue: push and resolve
// requests in, history-table update, redirect and status out.
interface branch_resolve_queue_if #(
   parameter int PC_W  = 32,
   parameter int IDX_W = 5
);
   logic             push;
   logic [PC_W-1:0]  push_pc;
   logic             push_pred;
   logic             resolve;
   logic             resolve_taken;
   logic [PC_W-1:0]  resolve_target;
   logic             upd_en;
   logic [IDX_W-1:0] upd_addr;
   logic             upd_taken;
   logic             mispredict;
   logic [PC_W-1:0]  redirect_pc;
   logic             full;
   logic             empty;
   logic             overflow;
   logic             underflow;
   logic [15:0]      mispredict_cnt;

   modport master (
      output push, push_pc, push_pred, resolve, resolve_taken, resolve_target,
      input  upd_en, upd_addr, upd_taken, mispredict, redirect_pc,
             full, empty, overflow, underflow, mispredict_cnt
   );

   modport slave (
      input  push, push_pc, push_pred, resolve, resolve_taken, resolve_target,
      output upd_en, upd_addr, upd_taken, mispredict, redirect_pc,
             full, empty, overflow, underflow, mispredict_cnt
   );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches; pops on resolve, updates the history
// table and raises a one-cycle redirect plus full flush on a misprediction.
module branch_resolve_queue #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32,
   parameter int IDX_W = 5
) (
   input logic                    clk,
   input logic                    arst_n,
   branch_resolve_queue_if.slave  bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} state_t;

   state_t             state_reg, state_next;
   logic [PTR_W-1:0]   wp_reg, wp_next, rp_reg, rp_next;
   logic [CNT_W-1:0]   count_reg, count_next;
   logic               upd_en_reg, upd_taken_reg, mispredict_reg;
   logic [IDX_W-1:0]   upd_addr_reg;
   logic [PC_W-1:0]    redirect_pc_reg, redirect_pc_next;
   logic               overflow_reg, underflow_reg;
   logic [15:0]        mispredict_cnt_reg, mispredict_cnt_next;

   logic [PC_W-1:0]    entry_pc [DEPTH];
   logic               entry_pred [DEPTH];
   logic [PC_W-1:0]    head_pc;
   logic               head_pred;
   logic               pop_valid, mis, push_ok, overflow_set, underflow_set;

   // Entry storage carries no reset: contents are meaningless until pushed.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [PC_W-1:0] pc_q;
      logic            pred_q;
      always_ff @(posedge clk) begin
         if (push_ok && wp_reg == PTR_W'(gi)) begin
            pc_q   <= bus.push_pc;
            pred_q <= bus.push_pred;
         end
      end
      assign entry_pc[gi]   = pc_q;
      assign entry_pred[gi] = pred_q;
   end

   assign head_pc   = entry_pc[rp_reg];
   assign head_pred = entry_pred[rp_reg];

   // A same-cycle push never feeds the resolve: only pre-edge entries count.
   assign pop_valid     = bus.resolve && (count_reg != '0);
   assign mis           = pop_valid && (head_pred != bus.resolve_taken);
   assign push_ok       = bus.push && !mis &&
                          ((count_reg != CNT_W'(DEPTH)) || pop_valid);
   assign overflow_set  = bus.push && !mis && !push_ok;
   assign underflow_set = bus.resolve && (count_reg == '0);

   always_comb begin
      wp_next             = wp_reg;
      rp_next             = rp_reg;
      count_next          = count_reg;
      redirect_pc_next    = redirect_pc_reg;
      mispredict_cnt_next = mispredict_cnt_reg;
      if (mis) begin
         wp_next          = '0;
         rp_next          = '0;
         count_next       = '0;
         redirect_pc_next = bus.resolve_taken ? bus.resolve_target
                                              : head_pc + PC_W'(4);
         if (mispredict_cnt_reg != 16'hFFFF)
            mispredict_cnt_next = mispredict_cnt_reg + 16'd1;
      end else begin
         if (push_ok)
            wp_next = wp_reg + PTR_W'(1);
         if (pop_valid)
            rp_next = rp_reg + PTR_W'(1);
         if (push_ok && !pop_valid)
            count_next = count_reg + CNT_W'(1);
         else if (!push_ok && pop_valid)
            count_next = count_reg - CNT_W'(1);
      end
   end

   always_comb begin
      state_next = ST_PARTIAL;
      if (count_next == '0)
         state_next = ST_EMPTY;
      else if (count_next == CNT_W'(DEPTH))
         state_next = ST_FULL;
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_reg          <= ST_EMPTY;
         wp_reg             <= '0;
         rp_reg             <= '0;
         count_reg          <= '0;
         upd_en_reg         <= 1'b0;
         upd_addr_reg       <= '0;
         upd_taken_reg      <= 1'b0;
         mispredict_reg     <= 1'b0;
         redirect_pc_reg    <= '0;
         overflow_reg       <= 1'b0;
         underflow_reg      <= 1'b0;
         mispredict_cnt_reg <= '0;
      end else begin
         state_reg          <= state_next;
         wp_reg             <= wp_next;
         rp_reg             <= rp_next;
         count_reg          <= count_next;
         upd_en_reg         <= pop_valid;
         upd_addr_reg       <= pop_valid ? head_pc[IDX_W+1:2] : '0;
         upd_taken_reg      <= pop_valid && bus.resolve_taken;
         mispredict_reg     <= mis;
         redirect_pc_reg    <= redirect_pc_next;
         overflow_reg       <= overflow_reg | overflow_set;
         underflow_reg      <= underflow_reg | underflow_set;
         mispredict_cnt_reg <= mispredict_cnt_next;
      end
   end

   assign bus.upd_en         = upd_en_reg;
   assign bus.upd_addr       = upd_addr_reg;
   assign bus.upd_taken      = upd_taken_reg;
   assign bus.mispredict     = mispredict_reg;
   assign bus.redirect_pc    = redirect_pc_reg;
   assign bus.full           = (state_reg == ST_FULL);
   assign bus.empty          = (state_reg == ST_EMPTY);
   assign bus.overflow       = overflow_reg;
   assign bus.underflow      = underflow_reg;
   assign bus.mispredict_cnt = mispredict_cnt_reg;
endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

Downstream companion of the 2-bit branch history table. Holds every fetched branch's PC and predicted direction in order until execute resolves it. On resolution it drives the history table's update port (enable, write index, taken). On a wrong prediction it raises a one-cycle redirect with the correct next PC and flushes younger in-flight branches.

## Interface
- DEPTH, 4, queue entries; power of two, 2..16
- PC_W, 32, program-counter width
- IDX_W, 5, history-table index width; index = pc[IDX_W+1:2]
- clk  in  1  clock, all state updates on rising edge
- arst_n  in  1  reset, asynchronous, active-low
- push  in  1  fetch issued a branch this cycle
- push_pc  in  PC_W  PC of that branch
- push_pred  in  1  prediction read from history table for that branch
- resolve  in  1  execute resolved the oldest branch this cycle
- resolve_taken  in  1  actual direction
- resolve_target  in  PC_W  actual taken target
- upd_en  out  1  history-table update strobe
- upd_addr  out  IDX_W  history-table write index
- upd_taken  out  1  history-table was_taken
- mispredict  out  1  one-cycle redirect strobe
- redirect_pc  out  PC_W  correct next PC, valid with mispredict
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- overflow  out  1  sticky: push attempted while full
- underflow  out  1  sticky: resolve while empty
- mispredict_cnt  out  16  saturating mispredict count

## Operation
- Circular FIFO with entries {pc, pred}, write pointer wp, read pointer rp, count 0..DEPTH. Pointers wrap modulo DEPTH.
- Push is accepted when count < DEPTH, or when count == DEPTH and a valid resolve happens in the same cycle. Otherwise the push is dropped and overflow is set.
- Resolve with count == 0 is ignored: no update, no redirect, underflow set. A same-cycle push is still accepted.
- Valid resolve pops the head entry h and registers:
  - upd_en=1
  - upd_addr=h.pc[IDX_W+1:2]
  - upd_taken=resolve_taken
- Mispredict when h.pred != resolve_taken. Registered outputs:
  - mispredict=1
  - redirect_pc = resolve_taken ? resolve_target : h.pc+4 (modulo 2^PC_W)
  - Flush: wp=rp=0, count=0; any same-cycle push is discarded and does not set overflow.
  - mispredict_cnt increments, saturating at 16'hFFFF.
- Correct prediction: pop only, mispredict=0.
- Simultaneous push and valid resolve without mispredict: count unchanged, both pointers advance.
- States: EMPTY (count=0), PARTIAL, FULL (count=DEPTH). Transitions:
  - push only: +1
  - resolve only: −1
  - both: 0
  - mispredict: → EMPTY
- overflow and underflow clear only on reset.

## Timing
- Reset values: upd_en=0, upd_addr=0, upd_taken=0, mispredict=0, redirect_pc=0, empty=1, full=0, overflow=0, underflow=0, mispredict_cnt=0. Pointers and count are 0; entry contents are don't-care.
- Latency: resolve in cycle N → upd_* and mispredict/redirect_pc valid in cycle N+1 for exactly one cycle. All four outputs are 0 otherwise; redirect_pc holds its last value.
- full/empty are registered and reflect count after edge N.
- A push in cycle N is resolvable from cycle N+1; same-cycle resolve never uses a same-cycle push.
- Reset asserted mid-operation clears everything immediately, independent of clk. Pending outputs are lost.

## Test plan
- Reset, then push pc=0x40 pred=0, resolve taken=0 → cycle+1: upd_en=1, upd_addr=0x10, upd_taken=0, mispredict=0, empty=1.
- Push pc=0x40 pred=0, resolve taken=1 target=0x100 → upd_taken=1, mispredict=1, redirect_pc=0x100, mispredict_cnt=1.
- Push 0x10,0x14,0x18 (pred=1) and resolve the first with taken=0 while pushing 0x1C → redirect_pc=0x14, queue empty, 0x1C discarded, overflow=0.
- Push 4 entries (DEPTH=4) → full=1. A 5th push alone → overflow=1, count 4. A 5th push with a correct resolve → accepted, count 4.
- Resolve when empty → underflow=1, upd_en stays 0. Same-cycle push pc=0x80 → count 1.
- Pointer wrap: 10 push/resolve pairs, pc=0x0..0x24 step 4, all correct → upd_addr sequence 0..9, no flags set. Then assert arst_n low mid-stream → all outputs at reset values before the next edge.
